s_rca_acc: RTL and testbench



---
 rtl/s_rca_acc.sv | 97 +++++++++
 tb/tb_s_rca_acc.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/s_rca_acc.sv
// Signed burst accumulator: sums BURST_LEN sign-extended adder words, then holds the total
// on a valid/ready port. Define S_RCA_ACC_SAT_EN to clamp the accumulator on overflow.
module s_rca_acc #(
    parameter int unsigned WIDTH     = 3,
    parameter int unsigned ACC_WIDTH = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf
);

    localparam int unsigned Msb     = ACC_WIDTH - 1;
    localparam logic [7:0]  LastCnt = 8'(BURST_LEN - 1);

`ifdef S_RCA_ACC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] AccMax = ~AccMin;
`endif

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e               state_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [7:0]           cnt_q;
    logic                 ovf_q;

    logic [ACC_WIDTH-1:0] in_ext;
    logic [ACC_WIDTH-1:0] sum;
    logic                 sum_ovf;

    // Sign-rule overflow: equal operand signs, result sign differs.
    always_comb begin
        in_ext  = ACC_WIDTH'($signed(in_data));
        sum     = acc_q + in_ext;
        sum_ovf = (acc_q[Msb] == in_ext[Msb]) && (sum[Msb] != acc_q[Msb]);
        acc_d   = sum;
`ifdef S_RCA_ACC_SAT_EN
        if (sum_ovf) begin
            acc_d = acc_q[Msb] ? AccMin : AccMax;
        end
`endif
    end

    // in_ready/out_valid are registered alongside the state so they never depend on inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StAccum;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                StAccum: begin
                    if (in_valid && in_ready) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 8'd1;
                        ovf_q <= ovf_q | sum_ovf;
                        if (cnt_q == LastCnt) begin
                            state_q   <= StHold;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (out_valid && out_ready) begin
                        state_q   <= StAccum;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        ovf_q     <= 1'b0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StAccum;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = acc_q;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_s_rca_acc.sv
// Scoreboard bench for s_rca_acc: default build, a 4-bit accumulator for overflow and a
// single-word burst instance, each with its own expected-result queue and monitor.
module tb_s_rca_acc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_out_ovf;
    logic [2:0] a_in_data = '0;
    logic [7:0] a_out_data;
    logic       b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_out_ovf;
    logic [2:0] b_in_data = '0;
    logic [3:0] b_out_data;
    logic       c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0, c_out_ovf;
    logic [2:0] c_in_data = '0;
    logic [7:0] c_out_data;

    int checks = 0;
    int errors = 0;

    logic [8:0] q_a[$];
    logic [4:0] q_b[$];
    logic [8:0] q_c[$];

    s_rca_acc #(.WIDTH(3), .ACC_WIDTH(8), .BURST_LEN(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_ovf(a_out_ovf)
    );
    s_rca_acc #(.WIDTH(3), .ACC_WIDTH(4), .BURST_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_ovf(b_out_ovf)
    );
    s_rca_acc #(.WIDTH(3), .ACC_WIDTH(8), .BURST_LEN(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_ovf(c_out_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            if (q_a.size() == 0) chk("a_unexpected_out", {23'd0, a_out_ovf, a_out_data}, 32'h1ff);
            else chk("a_out", {23'd0, a_out_ovf, a_out_data}, {23'd0, q_a.pop_front()});
        end
        if (b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) chk("b_unexpected_out", {27'd0, b_out_ovf, b_out_data}, 32'h1f);
            else chk("b_out", {27'd0, b_out_ovf, b_out_data}, {27'd0, q_b.pop_front()});
        end
        if (c_out_valid && c_out_ready) begin
            if (q_c.size() == 0) chk("c_unexpected_out", {23'd0, c_out_ovf, c_out_data}, 32'h1ff);
            else chk("c_out", {23'd0, c_out_ovf, c_out_data}, {23'd0, q_c.pop_front()});
        end
    end

    function automatic logic rdy(input int which);
        case (which)
            0:       return a_in_ready;
            1:       return b_in_ready;
            default: return c_in_ready;
        endcase
    endfunction

    // Present a word and hold it until the transfer edge; returns #1 after that edge.
    task automatic send(input int which, input logic [2:0] w);
        int n = 0;
        case (which)
            0:       begin a_in_valid = 1; a_in_data = w; end
            1:       begin b_in_valid = 1; b_in_data = w; end
            default: begin c_in_valid = 1; c_in_data = w; end
        endcase
        while (!rdy(which) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: dut %0d in_ready stuck at 0, expected 1", which);
        end
        @(posedge clk);
        #1;
        a_in_valid = 0;
        b_in_valid = 0;
        c_in_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        idle(2);
        rst = 0;
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        chk("rst_out_data", {24'd0, a_out_data}, 32'd0);
        chk("rst_out_ovf", {31'd0, a_out_ovf}, 32'd0);
        chk("rst_b_in_ready", {31'd0, b_in_ready}, 32'd1);
        chk("rst_c_in_ready", {31'd0, c_in_ready}, 32'd1);

        // Basic burst: +3 -3 +2 -1 = +1
        a_out_ready = 1;
        q_a.push_back({1'b0, 8'h01});
        send(0, 3'b011);
        send(0, 3'b101);
        send(0, 3'b010);
        send(0, 3'b111);
        chk("basic_lat_valid", {31'd0, a_out_valid}, 32'd1);
        chk("basic_in_ready", {31'd0, a_in_ready}, 32'd0);
        idle(1);

        // Backpressure: total +4 held for 5 cycles while in_valid is asserted
        a_out_ready = 0;
        q_a.push_back({1'b0, 8'h04});
        for (int i = 0; i < 4; i++) send(0, 3'b001);
        a_in_valid = 1;
        a_in_data  = 3'b011;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("bp_data_stable", {24'd0, a_out_data}, 32'h04);
            chk("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
            chk("bp_valid", {31'd0, a_out_valid}, 32'd1);
        end
        a_in_valid  = 0;
        a_out_ready = 1;
        idle(1);
        chk("bp_rel_in_ready", {31'd0, a_in_ready}, 32'd1);
        chk("bp_rel_acc", {24'd0, a_out_data}, 32'd0);
        chk("bp_rel_valid", {31'd0, a_out_valid}, 32'd0);

        // Gaps, then mid-burst reset discards the partial burst
        send(0, 3'b001);
        idle(2);
        send(0, 3'b001);
        idle(1);
        rst = 1;
        idle(1);
        rst = 0;
        chk("mrst_valid", {31'd0, a_out_valid}, 32'd0);
        chk("mrst_acc", {24'd0, a_out_data}, 32'd0);
        q_a.push_back({1'b0, 8'hF0});
        for (int i = 0; i < 4; i++) send(0, 3'b100);
        chk("mrst_lat_valid", {31'd0, a_out_valid}, 32'd1);
        idle(2);

        // Overflow on a 4-bit accumulator; sticky flag survives a return into range
        b_out_ready = 1;
`ifdef S_RCA_ACC_SAT_EN
        q_b.push_back({1'b1, 4'b0111});
        q_b.push_back({1'b1, 4'b1000});
`else
        q_b.push_back({1'b1, 4'b1100});
        q_b.push_back({1'b1, 4'b0000});
`endif
        for (int i = 0; i < 4; i++) send(1, 3'b011);
        idle(1);
        for (int i = 0; i < 4; i++) send(1, 3'b100);
        idle(2);

        // BURST_LEN = 1
        c_out_ready = 1;
        q_c.push_back({1'b0, 8'hFC});
        q_c.push_back({1'b0, 8'h03});
        send(2, 3'b100);
        chk("c_lat1", {31'd0, c_out_valid}, 32'd1);
        send(2, 3'b011);
        chk("c_lat2", {31'd0, c_out_valid}, 32'd1);
        idle(3);

        chk("a_queue_drained", q_a.size(), 32'd0);
        chk("b_queue_drained", q_b.size(), 32'd0);
        chk("c_queue_drained", q_c.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
